chime_alarm: RTL
================

CHIME_ALARM -- requirements
Module: chime_alarm

Interface
REQ-001 Parameter NUM_BEEPS, default 5, range 1..9: number of hourly chime beeps, ending at second 59.
REQ-002 Parameter RING_SECS, default 60, range 1..255: alarm ring duration in seconds.
REQ-003 Parameter SNOOZE_MIN, default 5, range 1..59: snooze delay in minutes.
REQ-004 CLK  input  1  system clock, all logic on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Hour, Minute, Second  input  8 each  BCD time of day from the counter chain.
REQ-007 _2Hz, _500Hz, _1kHz  input  1 each  square waves synchronous to CLK.
REQ-008 ChimeEn, AlarmEn  input  1 each  level enables for the hourly chime and the alarm.
REQ-009 AlarmHour, AlarmMinute  input  8 each  BCD alarm setpoint, Second implied 8'h00.
REQ-010 Snooze, Stop  input  1 each  single-CLK-cycle request pulses.
REQ-011 ALARM_Radio  output  1  beep envelope, high while a beep is sounding.
REQ-012 Speaker  output  1  tone-gated speaker drive.
REQ-013 Ringing  output  1  high in state RING.
REQ-014 Snoozed  output  1  high in state SNOOZE.

Function
REQ-015 All outputs SHALL be registered, with one CLK latency from the inputs that cause them.
REQ-016 Second-tick SHALL be asserted for one cycle when Second differs from its value one cycle earlier; it is suppressed in the first cycle after Reset.
REQ-017 Minute-tick SHALL be a second-tick whose new Second equals 8'h00.
REQ-018 Chime window SHALL be: ChimeEn=1, Minute=8'h59, and Second in BCD (60-NUM_BEEPS)..8'h59 (8'h55..8'h59 by default).
REQ-019 In the chime window and state IDLE: ALARM_Radio=_2Hz; Speaker=_2Hz AND _500Hz, except at Second=8'h59, where Speaker=_2Hz AND _1kHz (high final pip).
REQ-020 Alarm FSM states SHALL be IDLE, RING and SNOOZE.
REQ-021 IDLE->RING on a minute-tick with AlarmEn=1, Hour=AlarmHour and Minute=AlarmMinute; the ring counter loads RING_SECS.
REQ-022 In RING, each second-tick SHALL decrement the ring counter; the counter reaching 0 SHALL cause RING->IDLE.
REQ-023 RING with Snooze=1 SHALL go to SNOOZE and load the snooze counter with SNOOZE_MIN.
REQ-024 In SNOOZE, each minute-tick SHALL decrement the snooze counter; the counter reaching 0 SHALL cause SNOOZE->RING and reload the ring counter with RING_SECS.
REQ-025 Stop=1 in RING or SNOOZE SHALL go to IDLE; Stop has priority over Snooze in the same cycle.
REQ-026 AlarmEn=0 SHALL force IDLE from any state on the next edge.
REQ-027 Setpoint match SHALL be ignored in RING and SNOOZE, with no retrigger or counter reload.
REQ-028 Snooze in IDLE or SNOOZE and Stop in IDLE SHALL have no effect.
REQ-029 In RING: ALARM_Radio=_2Hz and Speaker=_2Hz AND _1kHz; the alarm overrides the chime when both apply.
REQ-030 In SNOOZE, with no chime active: ALARM_Radio=0 and Speaker=0.
REQ-031 Counters SHALL be wide enough for their parameter maxima (8-bit ring, 6-bit snooze) and SHALL never wrap below 0.
REQ-032 Tone inputs SHALL be used only as gating data, never as clocks.

Reset
REQ-033 Reset=1 SHALL force state IDLE, both counters to 0, the stored Second to 8'h00, and ALARM_Radio, Speaker, Ringing and Snoozed to 0 on the next edge.
REQ-034 Reset asserted mid-RING or mid-SNOOZE SHALL abort the alarm with no resume after deassertion.
REQ-035 The first cycle after Reset deasserts SHALL produce no second-tick or minute-tick, even if Second is nonzero.

Verification
REQ-036 Chime timing: ChimeEn=1, Minute=8'h59, Second stepped 8'h54->8'h00 -> ALARM_Radio follows _2Hz only at Seconds 55..59; Speaker uses _500Hz for 55..58 and _1kHz for 59.
REQ-037 Alarm ring: AlarmEn=1, setpoint 07:30, time rolls 07:29:59->07:30:00 -> Ringing=1 one cycle later, and Ringing=0 after exactly 60 second-ticks.
REQ-038 Snooze: Snooze pulse at ring second 10 -> Snoozed=1 with Speaker silent; after 5 minute-ticks Ringing=1 with a full 60 s duration.
REQ-039 Priority: Stop and Snooze in the same cycle during RING -> IDLE with Snoozed=0.
REQ-040 Override and abort: alarm ringing at xx:59:57 with ChimeEn=1 -> Speaker uses _1kHz continuously; Reset mid-RING -> all outputs 0 next edge, and no ring resumes after release.

Source files
------------

// File: rtl/chime_alarm.sv
// Hourly chime and alarm controller: derives second/minute ticks from the BCD
// time of day, runs the IDLE/RING/SNOOZE alarm FSM and gates the tone inputs
// onto the beep envelope and speaker outputs.
module chime_alarm #(
    parameter int unsigned NUM_BEEPS  = 5,
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [7:0] Hour,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    input  logic       _2Hz,
    input  logic       _500Hz,
    input  logic       _1kHz,
    input  logic       ChimeEn,
    input  logic       AlarmEn,
    input  logic [7:0] AlarmHour,
    input  logic [7:0] AlarmMinute,
    input  logic       Snooze,
    input  logic       Stop,
    output logic       ALARM_Radio,
    output logic       Speaker,
    output logic       Ringing,
    output logic       Snoozed
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RING   = 2'd1;
    localparam logic [1:0] SNOOZE = 2'd2;

    // First chime second as BCD, e.g. 8'h55 for five beeps ending at :59.
    localparam logic [3:0] CHIME_TENS  = 4'((60 - NUM_BEEPS) / 10);
    localparam logic [3:0] CHIME_ONES  = 4'((60 - NUM_BEEPS) % 10);
    localparam logic [7:0] CHIME_FIRST = {CHIME_TENS, CHIME_ONES};
    localparam logic [7:0] RING_LOAD   = 8'(RING_SECS);
    localparam logic [5:0] SNOOZE_LOAD = 6'(SNOOZE_MIN);

    logic [1:0] state_q, state_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic [5:0] snooze_cnt_q, snooze_cnt_d;
    logic [7:0] sec_q;
    logic       armed_q;

    logic       sec_tick;
    logic       min_tick;
    logic       alarm_match;
    logic       chime_win;
    logic       radio_d;
    logic       speaker_d;

    // Tick detection: armed_q masks the first cycle after reset, when sec_q
    // still holds its reset value rather than a real previous Second.
    always_comb begin
        sec_tick    = armed_q && (Second != sec_q);
        min_tick    = sec_tick && (Second == 8'h00);
        alarm_match = (Hour == AlarmHour) && (Minute == AlarmMinute);
        chime_win   = ChimeEn && (Minute == 8'h59) &&
                      (Second >= CHIME_FIRST) && (Second <= 8'h59);
    end

    // Alarm FSM next state and counter updates; counters stop at zero.
    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        if (!AlarmEn) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (min_tick && alarm_match) begin
                        state_d    = RING;
                        ring_cnt_d = RING_LOAD;
                    end
                end
                RING: begin
                    if (Stop) begin
                        state_d = IDLE;
                    end else if (Snooze) begin
                        state_d      = SNOOZE;
                        snooze_cnt_d = SNOOZE_LOAD;
                    end else if (sec_tick && (ring_cnt_q != 8'd0)) begin
                        ring_cnt_d = ring_cnt_q - 8'd1;
                        if (ring_cnt_q == 8'd1) begin
                            state_d = IDLE;
                        end
                    end
                end
                SNOOZE: begin
                    if (Stop) begin
                        state_d = IDLE;
                    end else if (min_tick && (snooze_cnt_q != 6'd0)) begin
                        snooze_cnt_d = snooze_cnt_q - 6'd1;
                        if (snooze_cnt_q == 6'd1) begin
                            state_d    = RING;
                            ring_cnt_d = RING_LOAD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so the tone outputs line up with
    // Ringing/Snoozed; the alarm tone overrides any chime.
    always_comb begin
        radio_d   = 1'b0;
        speaker_d = 1'b0;
        if (state_d == RING) begin
            radio_d   = _2Hz;
            speaker_d = _2Hz & _1kHz;
        end else if (chime_win) begin
            radio_d   = _2Hz;
            speaker_d = (Second == 8'h59) ? (_2Hz & _1kHz) : (_2Hz & _500Hz);
        end
    end

    // State, counters, stored Second and registered outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            sec_q        <= 8'h00;
            armed_q      <= 1'b0;
            ALARM_Radio  <= 1'b0;
            Speaker      <= 1'b0;
            Ringing      <= 1'b0;
            Snoozed      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            sec_q        <= Second;
            armed_q      <= 1'b1;
            ALARM_Radio  <= radio_d;
            Speaker      <= speaker_d;
            Ringing      <= (state_d == RING);
            Snoozed      <= (state_d == SNOOZE);
        end
    end

endmodule
